array_arb: RTL and testbench

Parametrised successor to the single-port test array: a W-bit, N-entry register array shared by C independent request channels. A round-robin arbiter grants at most one access per cycle, and reads return registered data one cycle later. It sits in the testbench utility library as the backing store for generated modules that expose more than one `Array` port, or that need back-pressure on array accesses.

---
 rtl/array_arb.sv | 153 +++++++++++++++
 tb/tb_array_arb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/array_arb.sv
// array_arb -- W-bit, N-entry register array shared by C request channels.
//
// A round-robin arbiter accepts at most one access per cycle. Writes land at
// the acceptance edge; reads return registered data one cycle after acceptance.
//
// Optional feature: define ARRAY_BOUNDS_EN to add the address range check
// (out-of-range writes are suppressed, out-of-range reads return zero, and
// the err port pulses). Without it the err port does not exist.
//
// Ports:
//   clk        rising-edge clock
//   nrst       asynchronous active-low reset
//   req_valid  [C]      per-channel request valid
//   req_ready  [C]      per-channel grant (combinational, one-hot or zero)
//   req_we     [C]      1 = write, 0 = read
//   req_addr   [C*AW]   packed addresses, channel k at [k*AW +: AW]
//   req_di     [C*W]    packed write data
//   rd_valid   [C]      one-cycle read-data strobe per channel
//   rd_do      [C*W]    packed read data, held until the next read
//   err        [C]      out-of-range pulse (ARRAY_BOUNDS_EN only)
module array_arb #(
  parameter int N = 16,
  parameter int W = 32,
  parameter int C = 2,
  localparam int AW = $clog2(N)
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [C-1:0]    req_valid,
  output logic [C-1:0]    req_ready,
  input  logic [C-1:0]    req_we,
  input  logic [C*AW-1:0] req_addr,
  input  logic [C*W-1:0]  req_di,
  output logic [C-1:0]    rd_valid,
  output logic [C*W-1:0]  rd_do
`ifdef ARRAY_BOUNDS_EN
  ,
  output logic [C-1:0]    err
`endif
);

  localparam int PW = (C > 1) ? $clog2(C) : 1;

  logic [PW-1:0] ptr_r;
  logic [W-1:0]  mem_r [N];

  logic          gnt_s;
  logic [PW-1:0] gnt_idx_s;
  logic          gnt_we_s;
  logic [AW-1:0] gnt_addr_s;
  logic [W-1:0]  gnt_di_s;
  logic          oob_s;
  logic [W-1:0]  rd_data_s;
  logic [C-1:0]  rd_hit_s;

  // Round-robin search: first pass covers channels at or above the pointer,
  // second pass wraps around to the channels below it.
  always_comb begin
    req_ready = {C{1'b0}};
    gnt_s     = 1'b0;
    for (int i = 0; i < C; i++) begin
      if (!gnt_s && req_valid[i] && (PW'(i) >= ptr_r)) begin
        req_ready[i] = 1'b1;
        gnt_s        = 1'b1;
      end else begin
        gnt_s = gnt_s;
      end
    end
    for (int i = 0; i < C; i++) begin
      if (!gnt_s && req_valid[i]) begin
        req_ready[i] = 1'b1;
        gnt_s        = 1'b1;
      end else begin
        gnt_s = gnt_s;
      end
    end
  end

  // Select the granted channel's payload from the one-hot grant.
  always_comb begin
    gnt_idx_s  = {PW{1'b0}};
    gnt_we_s   = 1'b0;
    gnt_addr_s = {AW{1'b0}};
    gnt_di_s   = {W{1'b0}};
    for (int i = 0; i < C; i++) begin
      if (req_ready[i]) begin
        gnt_idx_s  = PW'(i);
        gnt_we_s   = req_we[i];
        gnt_addr_s = req_addr[i*AW +: AW];
        gnt_di_s   = req_di[i*W +: W];
      end else begin
        gnt_idx_s = gnt_idx_s;
      end
    end
  end

`ifdef ARRAY_BOUNDS_EN
  // Extra bit so N == 2**AW compares correctly.
  assign oob_s = ({1'b0, gnt_addr_s} >= (AW+1)'(N));
`else
  assign oob_s = 1'b0;
`endif

  assign rd_data_s = oob_s ? {W{1'b0}} : mem_r[gnt_addr_s];
  assign rd_hit_s  = req_ready & ~req_we;

  // Arbiter pointer: moves just past the last granted channel.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptr_r <= {PW{1'b0}};
    end else if (gnt_s) begin
      ptr_r <= (gnt_idx_s == PW'(C-1)) ? {PW{1'b0}} : gnt_idx_s + PW'(1'b1);
    end
  end

  // Storage: reset loads each entry with its own index.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < N; i++) begin
        mem_r[i] <= W'(i);
      end
    end else if (gnt_s && gnt_we_s && !oob_s) begin
      mem_r[gnt_addr_s] <= gnt_di_s;
    end
  end

  // Read return: strobe for exactly one cycle, data held until next read.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_valid <= {C{1'b0}};
      rd_do    <= {(C*W){1'b0}};
    end else begin
      rd_valid <= rd_hit_s;
      for (int k = 0; k < C; k++) begin
        if (rd_hit_s[k]) begin
          rd_do[k*W +: W] <= rd_data_s;
        end
      end
    end
  end

`ifdef ARRAY_BOUNDS_EN
  // Out-of-range pulse on the granted channel, one cycle after acceptance.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err <= {C{1'b0}};
    end else begin
      err <= req_ready & {C{oob_s}};
    end
  end
`endif

endmodule

// File: tb/tb_array_arb.sv
module tb_array_arb;
  localparam int N  = 12;
  localparam int W  = 16;
  localparam int C  = 3;
  localparam int AW = $clog2(N);

  logic            clk = 1'b0;
  logic            nrst;
  logic [C-1:0]    req_valid;
  logic [C-1:0]    req_ready;
  logic [C-1:0]    req_we;
  logic [C*AW-1:0] req_addr;
  logic [C*W-1:0]  req_di;
  logic [C-1:0]    rd_valid;
  logic [C*W-1:0]  rd_do;
`ifdef ARRAY_BOUNDS_EN
  logic [C-1:0]    err;
`endif

  always #5 clk = ~clk;

  array_arb #(.N(N), .W(W), .C(C)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_di(req_di),
    .rd_valid(rd_valid), .rd_do(rd_do)
`ifdef ARRAY_BOUNDS_EN
    , .err(err)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Requester-side state
  logic       v  [C];
  logic       we [C];
  int         addr [C];
  logic [W-1:0] di [C];

  // Reference model
  logic [W-1:0] m_mem [N];
  int           m_ptr;
  logic [C-1:0] exp_rv, exp_err;
  logic [W-1:0] exp_do [C];
  logic [C-1:0] last_ready;
  int           last_g;
  int           gcnt [C];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_mem[i] = W'(i);
    m_ptr = 0;
    exp_rv = '0;
    exp_err = '0;
    for (int c = 0; c < C; c++) exp_do[c] = '0;
  endtask

  task automatic clear_req();
    for (int c = 0; c < C; c++) begin
      v[c] = 1'b0; we[c] = 1'b0; addr[c] = 0; di[c] = '0;
    end
  endtask

  task automatic set_req(input int c, input logic w, input int a, input logic [W-1:0] d);
    v[c] = 1'b1; we[c] = w; addr[c] = a; di[c] = d;
  endtask

  // One clock cycle: drive, check grant, advance model, check read return.
  task automatic step();
    int g;
    logic [C-1:0] exp_ready;
    for (int c = 0; c < C; c++) begin
      req_valid[c] = v[c];
      req_we[c] = we[c];
      req_addr[c*AW +: AW] = AW'(addr[c]);
      req_di[c*W +: W] = di[c];
    end
    #1;
    g = -1;
    for (int off = 0; off < C; off++) begin
      int ch;
      ch = (m_ptr + off) % C;
      if (g < 0 && v[ch]) g = ch;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    last_ready = req_ready;
    last_g = g;
    if (nrst) begin
      exp_rv = '0;
      exp_err = '0;
      if (g >= 0) begin
        logic oob;
        oob = (addr[g] >= N);
        m_ptr = (g + 1) % C;
        if (we[g]) begin
          if (!oob) m_mem[addr[g]] = di[g];
        end else begin
          exp_rv[g] = 1'b1;
          exp_do[g] = oob ? '0 : m_mem[addr[g]];
        end
        if (oob) exp_err[g] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("rd_valid", 64'(rd_valid), 64'(exp_rv));
    for (int c = 0; c < C; c++) chk("rd_do", 64'(rd_do[c*W +: W]), 64'(exp_do[c]));
`ifdef ARRAY_BOUNDS_EN
    chk("err", 64'(err), 64'(exp_err));
`endif
  endtask

  // Reset dropped between edges: outputs must clear immediately.
  task automatic async_reset();
    nrst = 1'b0;
    #1;
    model_reset();
    chk("rst_rd_valid", 64'(rd_valid), 64'(exp_rv));
    for (int c = 0; c < C; c++) chk("rst_rd_do", 64'(rd_do[c*W +: W]), 64'(exp_do[c]));
  endtask

  initial begin
    int hi;
    nrst = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_di = '0;
    clear_req();
    model_reset();
    @(posedge clk);
    #1;
    // Reset state, and ready follows valid while reset is held
    step();
    set_req(1, 1'b1, 4, 16'h1234);
    step();
    clear_req();
    nrst = 1'b1;
    step();

    // Read ch0 addr 5, then strobe must drop
    set_req(0, 1'b0, 5, '0);
    step();
    clear_req();
    step();

    // ch1 writes 0xDEAD to addr 3, ch0 reads it back next cycle
    set_req(1, 1'b1, 3, 16'hDEAD);
    step();
    clear_req();
    set_req(0, 1'b0, 3, '0);
    step();
    clear_req();
    step();

    // Write 7 to addr 2, leave a read pulse pending, reset mid-stream
    set_req(0, 1'b1, 2, 16'd7);
    step();
    clear_req();
    set_req(1, 1'b0, 2, '0);
    step();
    clear_req();
    async_reset();
    set_req(0, 1'b1, 2, 16'h0055);
    step();
    clear_req();
    nrst = 1'b1;
    set_req(2, 1'b0, 2, '0);
    step();
    clear_req();

    // Full contention from ptr 0: 0,1,2,0,1,2
    for (int c = 0; c < C; c++) gcnt[c] = 0;
    for (int c = 0; c < C; c++) set_req(c, 1'b0, c + 6, '0);
    for (int s = 0; s < 6; s++) begin
      step();
      chk("rr_order", 64'(last_g), 64'(s % C));
      for (int c = 0; c < C; c++) gcnt[c] += int'(last_ready[c]);
    end
    for (int c = 0; c < C; c++) chk("rr_count", 64'(gcnt[c]), 64'd2);
    clear_req();
    step();

    // ch0 alone: back-to-back reads of 0..3, one per cycle
    for (int a = 0; a < 4; a++) begin
      set_req(0, 1'b0, a, '0);
      step();
      chk("solo_ready", 64'(last_ready[0]), 64'd1);
    end
    clear_req();
    step();

`ifdef ARRAY_BOUNDS_EN
    // Out-of-range accesses
    set_req(0, 1'b1, 13, 16'd9);
    step();
    set_req(0, 1'b0, 13, '0);
    step();
    set_req(0, 1'b0, 11, '0);
    step();
    clear_req();
    step();
    hi = (1 << AW) - 1;
`else
    hi = N - 1;
`endif

    // Random traffic; pending requests are held until accepted
    clear_req();
    for (int s = 0; s < 400; s++) begin
      for (int c = 0; c < C; c++) begin
        if (!v[c] && ($urandom_range(0, 1) == 1)) begin
          set_req(c, 1'($urandom_range(0, 1)), int'($urandom_range(0, hi)), W'($urandom));
        end
      end
      step();
      if (last_g >= 0) v[last_g] = 1'b0;
    end
    clear_req();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
